// File: rtl/lab_pkg.sv
// Shared definitions for the hex counter lab blocks: active-low
// 7-segment glyphs (segment order g..a = bits 6..0) and a helper that
// sizes the prescaler register.
package lab_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Prescaler width: enough bits to hold 0..div-1, never less than one bit.
  function automatic int presc_width(input int div);
    if (div <= 1) begin
      return 1;
    end else begin
      return $clog2(div);
    end
  endfunction

endpackage

// File: rtl/hex_count_unit_decoder.sv
// One hexadecimal digit to active-low 7-segment glyph (A-F shown as A,b,C,d,E,F).
module hex_digit_decoder
  import lab_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Glyph lookup for the nibble.
  always_comb begin
    case (i_nibble)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_count_unit.sv
// Up/down modulo counter with prescaler, synchronous clamped load,
// one-cycle terminal-count pulse and per-nibble 7-segment outputs.
// Optional build macro HEX_COUNT_SATURATE_EN: the count saturates at
// 0 / MODULUS-1 instead of wrapping, and tc pulses on every step
// attempted at the limit.
module hex_count_unit
  import lab_pkg::*;
#(
  parameter int              WIDTH   = 16,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter int              DIV     = 1
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      up_down,
  input  logic                      load,
  input  logic [WIDTH-1:0]          load_value,
  output logic [WIDTH-1:0]          Q,
  output logic                      tc,
  output logic [7*(WIDTH/4)-1:0]    HEX
);

  localparam int               DIGITS     = WIDTH / 4;
  localparam int               PW         = presc_width(DIV);
  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE_Q      = WIDTH'(1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    ONE_P      = PW'(1);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_presc;
  logic             r_tc;

  logic [WIDTH-1:0] w_load_q;
  logic [WIDTH-1:0] w_step_q;
  logic             w_at_limit;
  logic             w_presc_last;

  // Clamp out-of-range load values to the top of the count range.
  always_comb begin
    if (load_value > MAX_Q) begin
      w_load_q = MAX_Q;
    end else begin
      w_load_q = load_value;
    end
  end

  // Limit detection in the current direction and end of the prescale period.
  always_comb begin
    if (up_down) begin
      w_at_limit = (r_q == MAX_Q);
    end else begin
      w_at_limit = (r_q == {WIDTH{1'b0}});
    end
    w_presc_last = (r_presc == PRESC_LAST);
  end

  // Count value after a step; the explicit limit compare keeps the
  // +/-1 arithmetic from ever overflowing outside the count range.
  always_comb begin
    if (w_at_limit) begin
`ifdef HEX_COUNT_SATURATE_EN
      w_step_q = r_q;
`else
      if (up_down) begin
        w_step_q = {WIDTH{1'b0}};
      end else begin
        w_step_q = MAX_Q;
      end
`endif
    end else if (up_down) begin
      w_step_q = r_q + ONE_Q;
    end else begin
      w_step_q = r_q - ONE_Q;
    end
  end

  // Count, prescaler and tc state: clear > load > step.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q     <= {WIDTH{1'b0}};
      r_presc <= {PW{1'b0}};
      r_tc    <= 1'b0;
    end else if (load) begin
      r_q     <= w_load_q;
      r_presc <= {PW{1'b0}};
      r_tc    <= 1'b0;
    end else if (enable) begin
      if (w_presc_last) begin
        r_presc <= {PW{1'b0}};
        r_q     <= w_step_q;
        r_tc    <= w_at_limit;
      end else begin
        r_presc <= r_presc + ONE_P;
        r_tc    <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign Q  = r_q;
  assign tc = r_tc;

  // One decoder per nibble of the count.
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      hex_digit_decoder u_dec (
        .i_nibble (r_q[4*k +: 4]),
        .o_seg    (HEX[7*k +: 7])
      );
    end
  endgenerate

endmodule

// File: tb/tb_hex_count_unit.sv
// Self-checking bench: three counter configurations driven by shared
// stimulus and compared every cycle against a behavioural model.
module tb_hex_count_unit;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        enable = 1'b0;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [15:0] ld_val = 16'h0000;

  logic [15:0] q0;  logic tc0; logic [27:0] hex0;
  logic [7:0]  q1;  logic tc1; logic [13:0] hex1;
  logic [15:0] q2;  logic tc2; logic [27:0] hex2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hex_count_unit #(.WIDTH(16)) u0 (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
    .load_value(ld_val), .Q(q0), .tc(tc0), .HEX(hex0));
  hex_count_unit #(.WIDTH(8), .MODULUS(10)) u1 (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
    .load_value(ld_val[7:0]), .Q(q1), .tc(tc1), .HEX(hex1));
  hex_count_unit #(.WIDTH(16), .MODULUS(1000), .DIV(4)) u2 (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down), .load(load),
    .load_value(ld_val), .Q(q2), .tc(tc2), .HEX(hex2));

  localparam logic [6:0] SEGS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] p;
    logic        tc;
  } mst_t;

  mst_t m [3];

  // Behavioural model of one clock edge (clear handled by the caller).
  function automatic mst_t mnext(input mst_t s, input logic [63:0] modv, input logic [63:0] divv,
                                 input bit ld, input logic [63:0] ldv, input bit en, input bit up);
    mst_t n;
    n = s;
    n.tc = 1'b0;
    if (ld) begin
      n.q = (ldv >= modv) ? modv - 64'd1 : ldv;
      n.p = 64'd0;
    end else if (en) begin
      if (s.p + 64'd1 == divv) begin
        n.p = 64'd0;
        if (up ? (s.q == modv - 64'd1) : (s.q == 64'd0)) begin
          n.tc = 1'b1;
`ifdef HEX_COUNT_SATURATE_EN
          n.q = s.q;
`else
          n.q = up ? 64'd0 : modv - 64'd1;
`endif
        end else begin
          n.q = up ? s.q + 64'd1 : s.q - 64'd1;
        end
      end else begin
        n.p = s.p + 64'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [27:0] exp_hex(input logic [63:0] q, input int digits);
    logic [27:0] h;
    h = 28'd0;
    for (int k = 0; k < digits; k++) h[7*k +: 7] = SEGS[q[4*k +: 4]];
    return h;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update, mirroring the asynchronous clear.
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      m[0] <= mnext(m[0], 64'd65536, 64'd1, load, {48'd0, ld_val}, enable, up_down);
      m[1] <= mnext(m[1], 64'd10, 64'd1, load, {56'd0, ld_val[7:0]}, enable, up_down);
      m[2] <= mnext(m[2], 64'd1000, 64'd4, load, {48'd0, ld_val}, enable, up_down);
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("u0_q", {48'd0, q0}, m[0].q);
      check("u0_tc", {63'd0, tc0}, {63'd0, m[0].tc});
      check("u0_hex", {36'd0, hex0}, {36'd0, exp_hex(m[0].q, 4)});
      check("u1_q", {56'd0, q1}, m[1].q);
      check("u1_tc", {63'd0, tc1}, {63'd0, m[1].tc});
      check("u1_hex", {50'd0, hex1}, {36'd0, exp_hex(m[1].q, 2)});
      check("u2_q", {48'd0, q2}, m[2].q);
      check("u2_tc", {63'd0, tc2}, {63'd0, m[2].tc});
      check("u2_hex", {36'd0, hex2}, {36'd0, exp_hex(m[2].q, 4)});
    end
  end

  task automatic step(input bit en, input bit ud, input bit ld, input logic [15:0] v);
    enable  = en;
    up_down = ud;
    load    = ld;
    ld_val  = v;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] e_q1;
  logic       e_tc1;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    clear  = 1'b0;
    chk_en = 1'b1;
    check("reset_q", {48'd0, q0}, 64'd0);
    check("reset_hex", {36'd0, hex0}, {36'd0, 28'b1000000_1000000_1000000_1000000});

    // Plain up count from reset.
    repeat (20) step(1'b1, 1'b1, 1'b0, 16'h0);
    check("t1_q", {48'd0, q0}, 64'h14);
    check("t1_hex0", {57'd0, hex0[6:0]}, 64'b0011001);
    check("t1_hex1", {57'd0, hex0[13:7]}, 64'b1111001);

    // Terminal count at both ends of a modulo-10 range.
    step(1'b0, 1'b1, 1'b1, 16'd9);
    step(1'b1, 1'b1, 1'b0, 16'h0);
`ifdef HEX_COUNT_SATURATE_EN
    check("t2_up_q", {56'd0, q1}, 64'd9);
`else
    check("t2_up_q", {56'd0, q1}, 64'd0);
`endif
    check("t2_up_tc", {63'd0, tc1}, 64'd1);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    check("t2_tc_gone", {63'd0, tc1}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 16'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
`ifdef HEX_COUNT_SATURATE_EN
    check("t2_dn_q", {56'd0, q1}, 64'd0);
`else
    check("t2_dn_q", {56'd0, q1}, 64'd9);
`endif
    check("t2_dn_tc", {63'd0, tc1}, 64'd1);

    // Prescaler freezes while enable is low.
    step(1'b0, 1'b1, 1'b1, 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("t3_q_3rd", {48'd0, q2}, 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("t3_q_4th", {48'd0, q2}, 64'd1);

    // Asynchronous clear between edges beats a simultaneous load.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check("t4_loaded", {48'd0, q0}, 64'h1234);
    clear  = 1'b1;
    load   = 1'b1;
    ld_val = 16'h0055;
    #1;
    check("t4_async_q", {48'd0, q0}, 64'd0);
    check("t4_async_hex", {36'd0, hex0}, {36'd0, 28'b1000000_1000000_1000000_1000000});
    @(posedge clk);
    #2;
    check("t4_held_q", {48'd0, q0}, 64'd0);
    clear = 1'b0;

    // Clamped load, then load overriding a half-done prescale.
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    check("t5_clamp", {48'd0, q2}, 64'd999);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'd5);
    check("t5_load_q", {48'd0, q2}, 64'd5);
    check("t5_load_tc", {63'd0, tc2}, 64'd0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
    check("t5_presc_restart", {48'd0, q2}, 64'd5);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    check("t5_step", {48'd0, q2}, 64'd6);

    // Stepping past the top: saturate or wrap.
    step(1'b0, 1'b1, 1'b1, 16'd9);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
`ifdef HEX_COUNT_SATURATE_EN
      e_q1  = 8'd9;
      e_tc1 = 1'b1;
`else
      e_q1  = 8'(i);
      e_tc1 = (i == 0);
`endif
      check("t6_q", {56'd0, q1}, {56'd0, e_q1});
      check("t6_tc", {63'd0, tc1}, {63'd0, e_tc1});
    end

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      clear = ($urandom_range(63, 0) == 0);
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(15, 0) == 0,
           ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(3, 0)));
    end
    clear = 1'b0;
    step(1'b0, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
